bus_memory: RTL and testbench

Bus responder on the far side of the CPU's word-addressed memory bus: it returns read data for whatever word address the CPU drives and commits masked byte writes. It backs instruction fetch, loads and stores with a single-ported RAM image. It also exposes a small MMIO page holding a buffered 8N1 serial console transmitter and a free-running cycle counter. It sits at top level directly between the CPU bus ports and the board's serial TX pin.

---
 rtl/bus_memory.sv | 218 +++++++++++++++++++++
 tb/tb_bus_memory.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory.sv
// rtl/bus_memory.sv - CPU bus responder: word RAM plus MMIO console UART and cycle counter.
module bus_memory #(
    parameter int    RAM_WORDS  = 4096,
    parameter string INIT_FILE  = "",
    parameter int    FIFO_DEPTH = 8,
    parameter int    BAUD_DIV   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    output logic [31:0] bus_data_r,
    input  logic [31:0] bus_data_w,
    input  logic [3:0]  bus_mask_w,
    input  logic        bus_write,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } ser_state_t;

    logic [31:0] ram [RAM_WORDS];

    logic          sel_mmio;
    logic [AW-1:0] ram_idx;
    logic [1:0]    mmio_reg;
    logic          ram_we;
    logic          uart_push;
    logic          status_wr;
    logic          unused_addr;

    assign sel_mmio    = bus_addr[31];
    assign ram_idx     = bus_addr[AW-1:0];
    assign mmio_reg    = bus_addr[1:0];
    assign ram_we      = bus_write & ~sel_mmio;
    assign uart_push   = bus_write & sel_mmio & (mmio_reg == 2'd0) & bus_mask_w[0];
    assign status_wr   = bus_write & sel_mmio & (mmio_reg == 2'd1) & (|bus_mask_w);
    // RAM aliases across the ignored upper address bits.
    assign unused_addr = ^bus_addr[30:AW];

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_mask_w[i]) begin
                    ram[ram_idx][8*i +: 8] <= bus_data_w[8*i +: 8];
                end
            end
        end
    end

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_ok;
    logic          pop;
    logic          overflow;

    ser_state_t    state;
    ser_state_t    state_next;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          tx_next;
    logic          baud_done;
    logic          tx_idle;
    logic [31:0]   cycle_count;

    assign fifo_full  = (fifo_count == FIFO_FULL);
    assign fifo_empty = (fifo_count == '0);
    // Fullness uses pre-edge state, so a pop on the same edge never makes room.
    assign push_ok    = uart_push & ~fifo_full;
    assign pop        = (state == S_IDLE) & ~fifo_empty;
    assign baud_done  = (baud_cnt == BAUD_LAST);
    assign tx_idle    = (state == S_IDLE) & fifo_empty;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus_data_w[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (PW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (uart_push && fifo_full) begin
                overflow <= 1'b1;
            end else if (status_wr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = uart_tx;
        case (state)
            S_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    state_next = S_START;
                    shift_next = fifo_mem[rd_ptr];
                    baud_next  = '0;
                    tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_next = S_DATA;
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    tx_next    = shift[0];
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next = {1'b0, shift[7:1]};
                        bit_next   = bit_idx + 3'd1;
                        tx_next    = shift[1];
                    end
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            S_STOP: begin
                tx_next = 1'b1;
                if (baud_done) begin
                    state_next = S_IDLE;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_cnt + BW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            uart_tx  <= tx_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    always_comb begin
        bus_data_r = 32'd0;
        if (!sel_mmio) begin
            bus_data_r = ram[ram_idx];
        end else begin
            case (mmio_reg)
                2'd1:    bus_data_r = {29'd0, overflow, tx_idle, fifo_full};
                2'd2:    bus_data_r = cycle_count;
                default: bus_data_r = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_memory.sv
// tb/tb_bus_memory.sv - randomized self-checking bench for bus_memory.
module tb_bus_memory;

    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int BAUD_DIV   = 4;
    localparam int FRAME      = 10 * BAUD_DIV;
    localparam logic [31:0] A_DATA = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0001;
    localparam logic [31:0] A_CYC  = 32'h8000_0002;
    localparam logic [31:0] A_RSV  = 32'h8000_0003;

    logic        clock;
    logic        reset;
    logic [31:0] bus_addr;
    logic [31:0] bus_data_r;
    logic [31:0] bus_data_w;
    logic [3:0]  bus_mask_w;
    logic        bus_write;
    logic        uart_tx;

    int          checks;
    int          errors;
    logic [31:0] ram_model [RAM_WORDS];
    logic [31:0] cyc_model;
    int          reset_edges;
    logic [7:0]  rx_q [$];

    bus_memory #(
        .RAM_WORDS (RAM_WORDS),
        .INIT_FILE (""),
        .FIFO_DEPTH(FIFO_DEPTH),
        .BAUD_DIV  (BAUD_DIV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_data_r(bus_data_r),
        .bus_data_w(bus_data_w),
        .bus_mask_w(bus_mask_w),
        .bus_write (bus_write),
        .uart_tx   (uart_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle count is simply rising edges since reset was last seen high.
    always @(posedge clock) begin
        cyc_model <= reset ? 32'd0 : cyc_model + 32'd1;
        if (reset) reset_edges <= reset_edges + 1;
    end

    // Line monitor: samples mid-bit and records complete frames untouched by reset.
    initial begin : line_monitor
        int         snap;
        logic [7:0] b;
        logic       ok_start;
        logic       stop_bit;
        forever begin
            @(negedge clock);
            if (uart_tx === 1'b0 && reset === 1'b0) begin
                snap = reset_edges;
                repeat (BAUD_DIV / 2) @(negedge clock);
                ok_start = (uart_tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) @(negedge clock);
                    b[i] = uart_tx;
                end
                repeat (BAUD_DIV) @(negedge clock);
                stop_bit = uart_tx;
                if (reset_edges == snap) begin
                    checks++;
                    if (!ok_start || stop_bit !== 1'b1) begin
                        errors++;
                        $display("FAIL monitor_frame start_ok=%0b stop=%b required start_ok=1 stop=1",
                                 ok_start, stop_bit);
                    end else begin
                        rx_q.push_back(b);
                    end
                end
            end
        end
    end

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clock);
        bus_addr   = a;
        bus_data_w = d;
        bus_mask_w = m;
        bus_write  = 1'b1;
        @(negedge clock);
        bus_write  = 1'b0;
        bus_mask_w = 4'd0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus_addr = a;
        #1 d = bus_data_r;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int idx;
        idx = int'(a % RAM_WORDS);
        for (int l = 0; l < 4; l++)
            if (m[l]) ram_model[idx][8*l +: 8] = d[8*l +: 8];
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++; $display("FAIL reset_tx got=%b want=1", uart_tx);
        end
        bus_rd(A_STAT, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL reset_status got=%h want=00000002", v);
        end
        bus_rd(A_CYC, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("FAIL reset_cycle got=%h want=00000000", v);
        end
    endtask

    task automatic test_ram_basic;
        logic [31:0] v;
        bus_wr(32'd0, 32'h0000_0013, 4'hF);
        model_write(32'd0, 32'h0000_0013, 4'hF);
        bus_rd(32'd0, v);
        checks++;
        if (v !== 32'h0000_0013) begin
            errors++; $display("FAIL ram_word0 got=%h want=00000013", v);
        end
        bus_wr(32'd5, 32'hAABB_CCDD, 4'hF);
        @(negedge clock);
        bus_addr   = 32'd5;
        bus_data_w = 32'h1122_3344;
        bus_mask_w = 4'b0101;
        bus_write  = 1'b1;
        #1;
        checks++;
        if (bus_data_r !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL ram_prewrite got=%h want=aabbccdd", bus_data_r);
        end
        @(negedge clock);
        bus_write = 1'b0;
        bus_rd(32'd5, v);
        checks++;
        if (v !== 32'hAA22_CC44) begin
            errors++; $display("FAIL ram_masked got=%h want=aa22cc44", v);
        end
        model_write(32'd5, 32'hAABB_CCDD, 4'hF);
        model_write(32'd5, 32'h1122_3344, 4'b0101);
    endtask

    task automatic test_ram_random;
        logic [31:0] v, a, d;
        logic [3:0]  m;
        for (int i = 0; i < RAM_WORDS; i++) begin
            if (i != 0 && i != 5) begin
                d = $urandom;
                bus_wr(i, d, 4'hF);
                model_write(i, d, 4'hF);
            end
        end
        d = $urandom;
        bus_wr(RAM_WORDS + 3, d, 4'hF);
        model_write(RAM_WORDS + 3, d, 4'hF);
        bus_rd(32'd3, v);
        checks++;
        if (v !== d) begin
            errors++; $display("FAIL ram_alias got=%h want=%h", v, d);
        end
        for (int i = 0; i < 60; i++) begin
            a = $urandom & 32'h7FFF_FFFF;
            if ($urandom_range(0, 1) == 1) begin
                if ((a % RAM_WORDS) == 0 || (a % RAM_WORDS) == 5) continue;
                d = $urandom;
                m = 4'($urandom_range(0, 15));
                bus_wr(a, d, m);
                model_write(a, d, m);
            end else begin
                bus_rd(a, v);
                checks++;
                if (v !== ram_model[a % RAM_WORDS]) begin
                    errors++;
                    $display("FAIL ram_random addr=%h got=%h want=%h", a, v, ram_model[a % RAM_WORDS]);
                end
            end
        end
    endtask

    task automatic test_mmio_misc;
        logic [31:0] v;
        bus_wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
        bus_wr(A_CYC, 32'h0, 4'hF);
        bus_rd(32'd3, v);
        checks++;
        if (v !== ram_model[3]) begin
            errors++; $display("FAIL mmio_no_ram_write got=%h want=%h", v, ram_model[3]);
        end
        bus_rd(A_CYC, v);
        checks++;
        if (v !== cyc_model) begin
            errors++; $display("FAIL cycle_write_ignored got=%h want=%h", v, cyc_model);
        end
        bus_rd(32'h8000_1236, v);
        checks++;
        if (v !== cyc_model) begin
            errors++; $display("FAIL mmio_alias_cycle got=%h want=%h", v, cyc_model);
        end
        bus_rd(A_DATA, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("FAIL uart_data_read got=%h want=0", v);
        end
        bus_rd(A_RSV, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("FAIL word3_read got=%h want=0", v);
        end
    endtask

    task automatic test_uart_frame;
        logic [7:0] byte_v;
        logic       exp_tx;
        int         k;
        byte_v = 8'hA5;
        rx_q.delete();
        bus_wr(A_DATA, {24'd0, byte_v}, 4'b0001);
        bus_addr = A_STAT;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++; $display("FAIL frame_pre_tx got=%b want=1", uart_tx);
        end
        for (int n = 1; n <= FRAME + 1; n++) begin
            @(negedge clock);
            #1;
            k = (n - 1) / BAUD_DIV;
            exp_tx = (k == 0) ? 1'b0 : (k <= 8) ? byte_v[k-1] : 1'b1;
            checks++;
            if (uart_tx !== exp_tx) begin
                errors++; $display("FAIL frame_tx cycle=%0d got=%b want=%b", n, uart_tx, exp_tx);
            end
            if (n >= FRAME) begin
                checks++;
                if (bus_data_r[1] !== (n == FRAME + 1)) begin
                    errors++;
                    $display("FAIL frame_idle cycle=%0d got=%b want=%b", n, bus_data_r[1], n == FRAME + 1);
                end
            end
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== byte_v) begin
            errors++; $display("FAIL frame_rx count=%0d want=1 byte=%h", rx_q.size(), byte_v);
        end
    endtask

    task automatic test_fifo_overflow;
        logic [7:0]  sent [$];
        logic [31:0] v;
        int          waited;
        rx_q.delete();
        @(negedge clock);
        for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
            sent.push_back(8'($urandom));
            bus_addr   = A_DATA;
            bus_data_w = {24'($urandom), sent[k]};
            bus_mask_w = 4'b0001;
            bus_write  = 1'b1;
            @(negedge clock);
        end
        bus_write  = 1'b0;
        bus_mask_w = 4'd0;
        bus_rd(A_STAT, v);
        checks++;
        if (v !== 32'h5) begin
            errors++; $display("FAIL overflow_status got=%h want=00000005", v);
        end
        bus_wr(A_STAT, 32'h0, 4'b0010);
        bus_rd(A_STAT, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL overflow_clear got=%h want=00000001", v);
        end
        waited = 0;
        bus_addr = A_STAT;
        #1;
        while (bus_data_r[1] !== 1'b1 && waited < (FIFO_DEPTH + 3) * (FRAME + 1)) begin
            @(negedge clock);
            #1;
            waited++;
        end
        checks++;
        if (bus_data_r[1] !== 1'b1) begin
            errors++; $display("FAIL fifo_drain_timeout status=%h want bit1=1", bus_data_r);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (rx_q.size() != FIFO_DEPTH + 1) begin
            errors++; $display("FAIL fifo_frame_count got=%0d want=%0d", rx_q.size(), FIFO_DEPTH + 1);
        end
        for (int k = 0; k < FIFO_DEPTH + 1 && k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[k] !== sent[k]) begin
                errors++; $display("FAIL fifo_byte idx=%0d got=%h want=%h", k, rx_q[k], sent[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] v;
        rx_q.delete();
        bus_wr(A_DATA, 32'h3C, 4'b0001);
        bus_wr(A_DATA, 32'h5A, 4'b0001);
        repeat (13) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++; $display("FAIL midframe_tx got=%b want=1", uart_tx);
        end
        bus_rd(A_STAT, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL midframe_status got=%h want=00000002", v);
        end
        bus_rd(32'd5, v);
        checks++;
        if (v !== ram_model[5]) begin
            errors++; $display("FAIL midframe_ram got=%h want=%h", v, ram_model[5]);
        end
        for (int n = 0; n < FRAME + 5; n++) begin
            @(negedge clock);
            #1;
            checks++;
            if (uart_tx !== 1'b1) begin
                errors++; $display("FAIL midframe_quiet cycle=%0d got=%b want=1", n, uart_tx);
            end
        end
        checks++;
        if (rx_q.size() != 0) begin
            errors++; $display("FAIL midframe_rx got=%0d frames want=0", rx_q.size());
        end
    endtask

    task automatic test_cycle;
        logic [31:0] v, base;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        bus_rd(A_CYC, v);
        checks++;
        if (v !== 32'd10) begin
            errors++; $display("FAIL cycle_10 got=%0d want=10", v);
        end
        @(negedge clock);
        force dut.cycle_count = 32'hFFFF_FFFD;
        @(negedge clock);
        release dut.cycle_count;
        @(negedge clock);
        bus_rd(A_CYC, base);
        checks++;
        if (base < 32'hFFFF_FFF0) begin
            errors++; $display("FAIL cycle_forced got=%h want>=fffffff0", base);
        end
        repeat (5) @(negedge clock);
        bus_rd(A_CYC, v);
        checks++;
        if (v !== base + 32'd5 || v > 32'd16) begin
            errors++; $display("FAIL cycle_wrap got=%h want=%h", v, base + 32'd5);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_edges = 0;
        reset       = 1'b1;
        bus_addr    = 32'd0;
        bus_data_w  = 32'd0;
        bus_mask_w  = 4'd0;
        bus_write   = 1'b0;
        test_reset;
        test_ram_basic;
        test_ram_random;
        test_mmio_misc;
        test_uart_frame;
        test_fifo_overflow;
        test_reset_mid_frame;
        test_cycle;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
